// File: rtl/counter_ctrl_pkg.sv
// Shared types and defaults for the counter run-control sequencer.
// Optional prescaler is enabled with COUNTER_CTRL_PRESCALE_EN.
package counter_ctrl_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_PRESCALE_W = 4;

    localparam logic [DEF_WIDTH-1:0] DEF_PERIOD = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/counter_ctrl_core.sv
// Counter datapath: synchronous clear, enable, wrap at the period.
// No control state lives here; counter_ctrl sequences it.
module counter_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    assign wrap = en && (value == period);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (en) begin
            value <= wrap ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Run-control FSM, configuration registers and tick/done outputs.
// Define COUNTER_CTRL_PRESCALE_EN to add the cfg_prescale divider.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
`ifdef COUNTER_CTRL_PRESCALE_EN
    ,
    parameter int PRESCALE_W = DEF_PRESCALE_W
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_we,
    input  logic [WIDTH-1:0]      cfg_period,
    input  logic                  cfg_oneshot,
`ifdef COUNTER_CTRL_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] cfg_prescale,
`endif
    input  logic                  start,
    input  logic                  stop,
    output logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  tick,
    output logic                  done
);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] period_r;
    logic             oneshot_r;
    logic             tick_r;
    logic             done_r;
    logic             en;
    logic             run_en;
    logic             clr;
    logic             wrap;
    logic             latch;
    logic             tick_nx;
    logic             done_nx;

    assign run_en = en && (state == RUN);

    always_comb begin
        state_nx = state;
        clr      = 1'b0;
        latch    = 1'b0;
        tick_nx  = 1'b0;
        done_nx  = done_r;
        unique case (state)
            IDLE: begin
                latch = cfg_we;
                if (start) begin
                    state_nx = RUN;
                    clr      = 1'b1;
                end
            end
            RUN: begin
                // stop outranks restart, which outranks a wrap
                if (stop) begin
                    state_nx = IDLE;
                    clr      = 1'b1;
                end else if (start) begin
                    clr = 1'b1;
                end else if (wrap) begin
                    tick_nx = 1'b1;
                    if (oneshot_r) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (stop) begin
                    state_nx = IDLE;
                    done_nx  = 1'b0;
                end else if (start) begin
                    state_nx = RUN;
                    done_nx  = 1'b0;
                    clr      = 1'b1;
                end else if (cfg_we) begin
                    latch    = 1'b1;
                    state_nx = IDLE;
                    done_nx  = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
                done_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            period_r  <= '1;
            oneshot_r <= 1'b0;
            tick_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state  <= state_nx;
            tick_r <= tick_nx;
            done_r <= done_nx;
            if (latch) begin
                period_r  <= cfg_period;
                oneshot_r <= cfg_oneshot;
            end
        end
    end

`ifdef COUNTER_CTRL_PRESCALE_EN
    logic [PRESCALE_W-1:0] pre_r;
    logic [PRESCALE_W-1:0] ps_cnt;

    assign en = (ps_cnt == pre_r);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_r  <= '0;
            ps_cnt <= '0;
        end else begin
            if (latch) begin
                pre_r <= cfg_prescale;
            end
            if (state != RUN || start || stop || en) begin
                ps_cnt <= '0;
            end else begin
                ps_cnt <= ps_cnt + 1'b1;
            end
        end
    end
`else
    assign en = 1'b1;
`endif

    counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .en    (run_en),
        .period(period_r),
        .value (value),
        .wrap  (wrap)
    );

    assign busy = (state == RUN);
    assign tick = tick_r;
    assign done = done_r;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl with a queue-based scoreboard.
// Define COUNTER_CTRL_PRESCALE_EN to exercise the prescaler path.
module tb_counter_ctrl;

    typedef struct packed {
        logic [7:0] value;
        logic       tick;
        logic       busy;
        logic       done;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [7:0] cfg_period;
    logic       cfg_oneshot;
`ifdef COUNTER_CTRL_PRESCALE_EN
    logic [3:0] cfg_prescale;
`endif
    logic       start;
    logic       stop;
    logic [7:0] value;
    logic       busy;
    logic       tick;
    logic       done;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    counter_ctrl dut (
        .clk         (clk),
        .reset       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_period  (cfg_period),
        .cfg_oneshot (cfg_oneshot),
`ifdef COUNTER_CTRL_PRESCALE_EN
        .cfg_prescale(cfg_prescale),
`endif
        .start       (start),
        .stop        (stop),
        .value       (value),
        .busy        (busy),
        .tick        (tick),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic expect_out(input logic [7:0] v, input logic t,
                              input logic b, input logic d);
        sb.push_back('{value: v, tick: t, busy: b, done: d});
    endtask

    task automatic check(input string tag);
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (value === e.value) else begin
            errors++;
            $error("FAIL %s value got %0d exp %0d", tag, value, e.value);
        end
        checks++;
        assert (tick === e.tick) else begin
            errors++;
            $error("FAIL %s tick got %b exp %b", tag, tick, e.tick);
        end
        checks++;
        assert (busy === e.busy) else begin
            errors++;
            $error("FAIL %s busy got %b exp %b", tag, busy, e.busy);
        end
        checks++;
        assert (done === e.done) else begin
            errors++;
            $error("FAIL %s done got %b exp %b", tag, done, e.done);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        start  = 1'b0;
        stop   = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_start(input logic [7:0] p, input logic os);
        cfg_we      = 1'b1;
        cfg_period  = p;
        cfg_oneshot = os;
        start       = 1'b1;
        step();
    endtask

    initial begin
        rst_n       = 1'b0;
        cfg_we      = 1'b0;
        cfg_period  = 8'd0;
        cfg_oneshot = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
        cfg_prescale = 4'd0;
`endif
        #1;
        expect_out(8'd0, 1'b0, 1'b0, 1'b0);
        check("reset");
        step();
        step();
        rst_n = 1'b1;
        step();
        expect_out(8'd0, 1'b0, 1'b0, 1'b0);
        check("idle");

        // periodic P=3, config and start together
        cfg_start(8'd3, 1'b0);
        expect_out(8'd0, 1'b0, 1'b1, 1'b0);
        check("p3_start");
        for (int i = 1; i <= 9; i++) begin
            step();
            expect_out(8'(i % 4), (i % 4) == 0, 1'b1, 1'b0);
            check("p3_run");
        end
        stop = 1'b1;
        step();
        expect_out(8'd0, 1'b0, 1'b0, 1'b0);
        check("p3_stop");

        // one-shot P=5
        cfg_start(8'd5, 1'b1);
        expect_out(8'd0, 1'b0, 1'b1, 1'b0);
        check("os_start");
        for (int i = 1; i <= 5; i++) begin
            step();
            expect_out(8'(i), 1'b0, 1'b1, 1'b0);
            check("os_run");
        end
        step();
        expect_out(8'd0, 1'b1, 1'b0, 1'b1);
        check("os_wrap");
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out(8'd0, 1'b0, 1'b0, 1'b1);
            check("os_hold");
        end
        start = 1'b1;
        step();
        expect_out(8'd0, 1'b0, 1'b1, 1'b0);
        check("os_restart");
        stop = 1'b1;
        step();
        expect_out(8'd0, 1'b0, 1'b0, 1'b0);
        check("os_stop");

        // P=10, stop and start together at the wrap point
        cfg_start(8'd10, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            step();
        end
        expect_out(8'd10, 1'b0, 1'b1, 1'b0);
        check("p10_top");
        stop  = 1'b1;
        start = 1'b1;
        step();
        expect_out(8'd0, 1'b0, 1'b0, 1'b0);
        check("stop_beats");
        step();
        expect_out(8'd0, 1'b0, 1'b0, 1'b0);
        check("stop_idle");

        // restart at value 2, cfg_we in RUN ignored
        cfg_start(8'd10, 1'b0);
        step();
        step();
        expect_out(8'd2, 1'b0, 1'b1, 1'b0);
        check("rs_pre");
        start      = 1'b1;
        cfg_we     = 1'b1;
        cfg_period = 8'd7;
        step();
        expect_out(8'd0, 1'b0, 1'b1, 1'b0);
        check("rs_restart");
        for (int i = 1; i <= 11; i++) begin
            step();
            expect_out(8'(i % 11), i == 11, 1'b1, 1'b0);
            check("rs_run");
        end
        stop = 1'b1;
        step();

        // P=0: tick every cycle
        cfg_start(8'd0, 1'b0);
        expect_out(8'd0, 1'b0, 1'b1, 1'b0);
        check("p0_start");
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out(8'd0, 1'b1, 1'b1, 1'b0);
            check("p0_run");
        end
        stop = 1'b1;
        step();

        // P=255: full range, tick every 256 cycles
        cfg_start(8'd255, 1'b0);
        for (int i = 1; i <= 257; i++) begin
            step();
            expect_out(8'(i % 256), i == 256, 1'b1, 1'b0);
            check("p255_run");
        end
        stop = 1'b1;
        step();

        // asynchronous reset mid-count
        cfg_start(8'd10, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
        end
        expect_out(8'd4, 1'b0, 1'b1, 1'b0);
        check("ar_pre");
        #2;
        rst_n = 1'b0;
        #1;
        expect_out(8'd0, 1'b0, 1'b0, 1'b0);
        check("ar_async");
        step();
        rst_n = 1'b1;
        step();
        expect_out(8'd0, 1'b0, 1'b0, 1'b0);
        check("ar_after");

`ifdef COUNTER_CTRL_PRESCALE_EN
        // prescale 2, P=1: value steps every 3 clocks, tick every 6
        cfg_prescale = 4'd2;
        cfg_start(8'd1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            step();
            expect_out(8'((i / 3) % 2), (i % 6) == 0, 1'b1, 1'b0);
            check("ps_run");
        end
        stop = 1'b1;
        step();
`endif

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_empty got %0d exp 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Run-control sequencer for the free-running 8-bit counter datapath. Holds a programmable period and mode, starts and stops the counter, wraps it at the period, and emits a one-cycle `tick` per wrap in either periodic or one-shot mode. Sits between the control logic, which issues start, stop and configuration, and any logic that consumes `value` and `tick`.

## Interface
- `WIDTH`, default 8: counter and period width.
- `PRESCALE_W`, default 4: prescaler divisor width. Used only when the prescaler is compiled in.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous reset, active-low. Asserted at 0.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_period`  in  WIDTH  terminal count P.
- `cfg_oneshot`  in  1  1 = one-shot mode, 0 = periodic mode.
- `cfg_prescale`  in  PRESCALE_W  divisor minus 1. Present only with `COUNTER_CTRL_PRESCALE_EN`.
- `start`  in  1  start or restart pulse.
- `stop`  in  1  abort pulse.
- `value`  out  WIDTH  current count.
- `busy`  out  1  high in RUN.
- `tick`  out  1  one-cycle wrap pulse, registered.
- `done`  out  1  one-shot complete, level.

## Operation
- States: IDLE, RUN, DONE.
- Reset values:
  - state = IDLE
  - `value` = 0, `busy` = 0, `tick` = 0, `done` = 0
  - period register = {WIDTH{1'b1}}, oneshot register = 0, prescaler = 0
- The enable `en` is 1 every cycle when the prescaler is compiled out.
- IDLE:
  - `start` → RUN, `value` ← 0.
  - `cfg_we` → latch `cfg_period` and `cfg_oneshot`.
  - `start` and `cfg_we` in the same cycle: configuration is latched first and the run uses the new values.
- RUN:
  - `en` and `value` < P: `value` ← `value` + 1.
  - `en` and `value` == P: `value` ← 0 and `tick` ← 1. In one-shot mode, also go to DONE with `done` ← 1.
  - `stop` → IDLE, `value` ← 0, no tick. `stop` beats `start` and beats a wrap in the same cycle.
  - `start` without `stop` → restart: `value` ← 0, no tick, state stays RUN.
  - `cfg_we` is ignored in RUN.
- DONE:
  - `value` holds 0 and `done` holds 1.
  - `start` → RUN, `done` ← 0.
  - `cfg_we` → latch configuration, `done` ← 0, go to IDLE.
  - `stop` → IDLE, `done` ← 0.
- Arithmetic: unsigned, modulo 2^WIDTH. `value` never exceeds P.
  - P = 0: `tick` fires on every `en` and `value` stays 0.
  - P = 2^WIDTH − 1: the count passes through all 2^WIDTH values.
- `reset` asserted mid-run returns every register to its reset value immediately, without waiting for a clock edge.

## Timing
- `start` sampled at edge k: from edge k, `value` = 0 and `busy` = 1.
- Periodic mode, prescaler off: `tick` is high for one cycle after edges k+P+1, k+2(P+1), …, coinciding with `value` = 0.
- One-shot mode: `tick` and `done` rise together after edge k+P+1. `busy` falls on the same edge.
- `stop` at edge j: `busy` = 0 and `value` = 0 from edge j.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `COUNTER_CTRL_PRESCALE_EN` defined:
  - Adds the `cfg_prescale` port and a prescale register, latched with the rest of the configuration.
  - `en` pulses once every `cfg_prescale` + 1 clocks.
  - The prescaler clears to 0 on `start`, on `stop`, and on entry to RUN. The first `en` comes `cfg_prescale` + 1 clocks after `start`.
- `COUNTER_CTRL_PRESCALE_EN` undefined: no `cfg_prescale` port, `en` is tied to 1, and timing is as stated above.

## Structure
- Shared package `counter_ctrl_pkg`:
  - state encoding: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2
  - default period constant
  - default `WIDTH` and `PRESCALE_W`
- Sub-module `counter_core`: WIDTH-bit register with synchronous clear, enable and wrap-at-P. It contains no FSM.
- `counter_ctrl` holds the FSM, the configuration registers, the prescaler and the `tick`/`done` registers.

## Test plan
- Reset, then P = 3, periodic, `start`: `value` sequence 0,1,2,3,0,…; `tick` high one cycle at every `value` = 0 after the first wrap, period 4 cycles.
- P = 5, one-shot, `start`: exactly one `tick` after 6 cycles; `done` stays 1 and `busy` 0 until the next `start`.
- P = 10, `stop` and `start` asserted together at `value` = 10: IDLE, `value` = 0, no `tick`.
- `start` pulsed at `value` = 2 while running: `value` returns to 0 and the full period restarts. `cfg_we` with P = 7 during RUN is ignored.
- P = 0 and P = 255: `tick` on every cycle, and `tick` every 256 cycles, respectively.
- `reset` driven low mid-count at `value` = 4: all outputs 0 immediately. Built with `COUNTER_CTRL_PRESCALE_EN` and `cfg_prescale` = 2, P = 1: `tick` every 6 clocks.
